// File: rtl/div_8by4.sv
// rtl/div_8by4.sv - sequential restoring divider, DW-bit dividend by VW-bit divisor
module div_8by4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic [DW-1:0] A,
    input  logic [VW-1:0] B,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          done,
    output logic          dz,
    output logic          busy
);
    localparam int CW = $clog2(DW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [DW-1:0] d_sh;
    logic [VW:0]   p_rem;
    logic [DW-1:0] q_sh;
    logic [VW-1:0] b_cp;
    logic [CW-1:0] cnt;

    logic [VW:0]   trial;
    logic [VW:0]   diff;
    logic          fits;

    // Shifted partial remainder is at most 2B-1, so one extra bit suffices.
    always_comb begin
        trial = {p_rem[VW-1:0], d_sh[DW-1]};
        diff  = trial - {1'b0, b_cp};
        fits  = (trial >= {1'b0, b_cp});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            d_sh  <= '0;
            p_rem <= '0;
            q_sh  <= '0;
            b_cp  <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            done  <= 1'b0;
            dz    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (init) begin
                        d_sh  <= A;
                        b_cp  <= B;
                        p_rem <= '0;
                        q_sh  <= '0;
                        cnt   <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (fits) begin
                        p_rem <= diff;
                        q_sh  <= {q_sh[DW-2:0], 1'b1};
                    end else begin
                        p_rem <= trial;
                        q_sh  <= {q_sh[DW-2:0], 1'b0};
                    end
                    d_sh <= {d_sh[DW-2:0], 1'b0};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(DW - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Results are published here only, so q/r/dz stay stable between dones.
                    done  <= 1'b1;
                    q     <= q_sh;
                    r     <= p_rem[VW-1:0];
                    dz    <= (b_cp == '0);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
endmodule
